// File: rtl/miriscv_irq_pkg.sv
// Shared types and constants for the miriscv external-interrupt arbiter.
// Holds the arbiter state encoding and the mcause formatting helper.
package miriscv_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam int unsigned MCAUSE_INT_BIT     = 31;
    localparam int unsigned DEFAULT_CAUSE_BASE = 16;

    // Interrupt causes carry the interrupt flag in the top bit of mcause.
    function automatic logic [31:0] make_mcause(input int unsigned code);
        logic [31:0] cause;
        cause                 = code;
        cause[MCAUSE_INT_BIT] = 1'b1;
        return cause;
    endfunction

endpackage

// File: rtl/miriscv_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module miriscv_rr_picker #(
    parameter  int unsigned N     = 6,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    int unsigned cand;

    // NOTE: every output gets a default before the search loop, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_valid && req[IDX_W'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/miriscv_irq_arbiter.sv
// External interrupt arbiter: edge-detected pending bits, round-robin choice,
// and a REQ/SERVICE handshake with the core (ack on trap entry, mret on exit).
module miriscv_irq_arbiter
    import miriscv_irq_pkg::*;
#(
    parameter int unsigned N_IRQ      = 6,
    parameter int unsigned CAUSE_BASE = DEFAULT_CAUSE_BASE
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             irq_ack_i,
    input  logic             mret_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] irq_fin_o,
    output logic             busy_o
);

    localparam int unsigned      IDX_W    = $clog2(N_IRQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IRQ - 1);

    irq_state_e       state_q,   state_d;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] fin_q,     fin_d;
    logic [IDX_W-1:0] sel_q,     sel_d;
    logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [31:0]      mcause_q,  mcause_d;

    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] pending_clr;
    logic [N_IRQ-1:0] sel_onehot;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    assign irq_rise   = irq_i & ~prev_q;
    assign eligible   = pending_q & mie_i;
    assign sel_onehot = {{(N_IRQ-1){1'b0}}, 1'b1} << sel_q;

    miriscv_rr_picker #(
        .N (N_IRQ)
    ) u_rr_picker (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        mcause_d    = mcause_q;
        pending_clr = '0;
        fin_d       = '0;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    sel_d    = gnt_idx;
                    mcause_d = make_mcause(CAUSE_BASE + 32'(gnt_idx));
                    state_d  = REQ;
                end
            end
            REQ: begin
                // Acknowledge beats a simultaneous mask drop: the trap is already taken.
                if (irq_ack_i) begin
                    pending_clr = sel_onehot;
                    state_d     = SERVICE;
                end else if (!mie_i[sel_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (mret_i) begin
                    fin_d    = sel_onehot;
                    rr_ptr_d = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on a line being cleared keeps it pending.
        pending_d = (pending_q & ~pending_clr) | irq_rise;
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            fin_q     <= '0;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            mcause_q  <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= irq_i;
            pending_q <= pending_d;
            fin_q     <= fin_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            mcause_q  <= mcause_d;
        end
    end

    assign int_o     = (state_q == REQ);
    assign busy_o    = (state_q != IDLE);
    assign mcause_o  = mcause_q;
    assign irq_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_irq_arbiter.sv
// Directed bench for miriscv_irq_arbiter with an expected-cause and
// expected-completion scoreboard.
module tb_miriscv_irq_arbiter;

    localparam int unsigned N = 6;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [N-1:0] irq_i;
    logic [N-1:0] mie_i;
    logic         irq_ack_i;
    logic         mret_i;
    logic         int_o;
    logic [31:0]  mcause_o;
    logic [N-1:0] irq_fin_o;
    logic         busy_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  exp_cause_q[$];
    logic [N-1:0] exp_fin_q[$];

    miriscv_irq_arbiter #(
        .N_IRQ      (N),
        .CAUSE_BASE (16)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .irq_i     (irq_i),
        .mie_i     (mie_i),
        .irq_ack_i (irq_ack_i),
        .mret_i    (mret_i),
        .int_o     (int_o),
        .mcause_o  (mcause_o),
        .irq_fin_o (irq_fin_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        rst_n_i   = 1'b0;
        irq_i     = '0;
        mie_i     = '0;
        irq_ack_i = 1'b0;
        mret_i    = 1'b0;
        #1;
        check({tag, "_int"},    32'(int_o),     32'd0);
        check({tag, "_busy"},   32'(busy_o),    32'd0);
        check({tag, "_mcause"}, mcause_o,       32'd0);
        check({tag, "_fin"},    32'(irq_fin_o), 32'd0);
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    // Waits (bounded) for int_o, optionally checks the cycle count, then pops the cause.
    task automatic expect_int(input string tag, input int max_cyc, input int lat);
        int          c;
        logic [31:0] exp;
        c = 0;
        while (int_o !== 1'b1 && c < max_cyc) begin
            tick();
            c++;
        end
        check({tag, "_seen"}, 32'(int_o), 32'd1);
        if (lat >= 0) begin
            check({tag, "_lat"}, 32'(c), 32'(lat));
        end
        exp = (exp_cause_q.size() > 0) ? exp_cause_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_mcause"}, mcause_o, exp);
    endtask

    task automatic do_ack(input string tag);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check({tag, "_svc_busy"}, 32'(busy_o), 32'd1);
        check({tag, "_svc_int"},  32'(int_o),  32'd0);
    endtask

    task automatic do_mret(input string tag);
        logic [N-1:0] exp;
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        exp = (exp_fin_q.size() > 0) ? exp_fin_q.pop_front() : 'x;
        check({tag, "_fin"}, 32'(irq_fin_o), 32'(exp));
        tick();
        check({tag, "_fin_1cyc"}, 32'(irq_fin_o), 32'd0);
    endtask

    initial begin
        int hits;

        // Reset values
        apply_reset("rst0");
        mie_i = 6'h3F;
        tick();

        // Single request on line 3: two-cycle latency, cause 0x13, completion pulse
        irq_i = 6'b001000;
        exp_cause_q.push_back(32'h8000_0013);
        exp_fin_q.push_back(6'b001000);
        expect_int("t1", 6, 2);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        check("t1_mret_in_req_int", 32'(int_o),     32'd1);
        check("t1_mret_in_req_fin", 32'(irq_fin_o), 32'd0);
        irq_i = '0;
        do_ack("t1");
        do_mret("t1");

        // Simultaneous lines 1 and 4 with rr_ptr=0
        apply_reset("rst1");
        mie_i = 6'h3F;
        irq_i = 6'b010010;
        exp_cause_q.push_back(32'h8000_0011);
        exp_cause_q.push_back(32'h8000_0014);
        exp_fin_q.push_back(6'b000010);
        exp_fin_q.push_back(6'b010000);
        expect_int("t2a", 6, 2);
        do_ack("t2a");
        irq_i = '0;
        do_mret("t2a");
        expect_int("t2b", 3, -1);
        do_ack("t2b");
        do_mret("t2b");

        // Masked line 5 stays quiet until enabled
        mie_i = 6'b011111;
        irq_i = 6'b100000;
        hits  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int_o !== 1'b0) hits++;
        end
        check("t3_masked_quiet", 32'(hits), 32'd0);
        mie_i = 6'h3F;
        exp_cause_q.push_back(32'h8000_0015);
        exp_fin_q.push_back(6'b100000);
        expect_int("t3", 2, -1);
        irq_i = '0;
        do_ack("t3");
        do_mret("t3");

        // Line 2: mask drop in REQ, re-request, edge coinciding with ack
        irq_i = 6'b000100;
        exp_cause_q.push_back(32'h8000_0012);
        expect_int("t4a", 6, 2);
        mie_i = 6'b111011;
        irq_i = '0;
        tick();
        check("t4_mask_int",  32'(int_o),  32'd0);
        check("t4_mask_busy", 32'(busy_o), 32'd0);
        mie_i = 6'h3F;
        exp_cause_q.push_back(32'h8000_0012);
        expect_int("t4b", 3, -1);
        irq_i = 6'b000100;
        exp_fin_q.push_back(6'b000100);
        do_ack("t4b");
        do_mret("t4b");
        exp_cause_q.push_back(32'h8000_0012);
        exp_fin_q.push_back(6'b000100);
        expect_int("t4c", 3, -1);
        irq_i = '0;
        do_ack("t4c");
        do_mret("t4c");

        // Stray ack/mret while idle are ignored
        irq_ack_i = 1'b1;
        mret_i    = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        mret_i    = 1'b0;
        check("t_stray_busy", 32'(busy_o),    32'd0);
        check("t_stray_fin",  32'(irq_fin_o), 32'd0);

        // Reset during SERVICE, late mret, line still high at release
        irq_i = 6'b000001;
        exp_cause_q.push_back(32'h8000_0010);
        expect_int("t5a", 6, 2);
        do_ack("t5a");
        rst_n_i = 1'b0;
        mret_i  = 1'b1;
        #1;
        check("t5_rst_int",    32'(int_o),     32'd0);
        check("t5_rst_busy",   32'(busy_o),    32'd0);
        check("t5_rst_mcause", mcause_o,       32'd0);
        check("t5_rst_fin",    32'(irq_fin_o), 32'd0);
        hits = 0;
        tick();
        if (irq_fin_o !== '0) hits++;
        tick();
        if (irq_fin_o !== '0) hits++;
        rst_n_i = 1'b1;
        tick();
        if (irq_fin_o !== '0) hits++;
        mret_i = 1'b0;
        check("t5_late_mret_busy", 32'(busy_o), 32'd0);
        check("t5_no_fin",         32'(hits),   32'd0);
        exp_cause_q.push_back(32'h8000_0010);
        exp_fin_q.push_back(6'b000001);
        expect_int("t5b", 4, 1);
        do_ack("t5b");
        irq_i = '0;
        do_mret("t5b");

        check("scoreboard_drained", 32'(exp_cause_q.size() + exp_fin_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
